// File: rtl/ir_pkg.sv
// ir_pkg: opcode map, default widths and sequencer state encoding shared by
// the fetch sequencer and the execute-stage decoder.
package ir_pkg;

  localparam int PC_W_DEF = 8;
  localparam int OP_W_DEF = 6;
  localparam int IR_W_DEF = 16;

  localparam logic [5:0] OP_HLT = 6'd0;
  localparam logic [5:0] OP_CLA = 6'd1;
  localparam logic [5:0] OP_COM = 6'd2;
  localparam logic [5:0] OP_SHR = 6'd3;
  localparam logic [5:0] OP_CSL = 6'd4;
  localparam logic [5:0] OP_ADD = 6'd6;
  localparam logic [5:0] OP_STA = 6'd7;
  localparam logic [5:0] OP_LDA = 6'd8;
  localparam logic [5:0] OP_JMP = 6'd9;
  localparam logic [5:0] OP_BAN = 6'd10;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    ISSUE = 2'd1,
    HALT  = 2'd2
  } state_t;

endpackage

// File: rtl/ir_branch_unit.sv
// ir_branch_unit: combinational next-PC selection (JMP, BAN, increment).
// Branch targets use only operand[7:0]; PC arithmetic wraps modulo 2^PC_W.
module ir_branch_unit
  import ir_pkg::*;
#(
  parameter int PC_W = PC_W_DEF,
  parameter int OP_W = OP_W_DEF
) (
  input  logic [OP_W-1:0] opcode,
  input  logic [9:0]      operand,
  input  logic [PC_W-1:0] pc,
  input  logic            acc_neg,
  output logic [PC_W-1:0] next_pc
);

  logic [PC_W-1:0] target;
  logic            unused_hi;

  // upper operand bits never reach the PC
  assign unused_hi = ^operand[9:8];
  assign target    = PC_W'(operand[7:0]);

  // redirect on JMP or taken BAN, otherwise fall through
  always_comb begin
    next_pc = pc + PC_W'(1);
    if (opcode == OP_W'(OP_JMP))
      next_pc = target;
    else if (opcode == OP_W'(OP_BAN) && acc_neg)
      next_pc = target;
  end

endmodule

// File: rtl/ir_fetch_seq.sv
// ir_fetch_seq: FETCH/ISSUE instruction sequencer in front of a combinational
// ROM. Each instruction is captured in FETCH, presented with valid/ready in
// ISSUE, and the PC advances at acceptance.
// Optional feature macro IRF_HALT_EN: opcode 0 parks the sequencer in HALT
// (never issued, pc frozen at the HLT address, halted=1). Without it opcode 0
// is an ordinary NOP and halted is tied low.
module ir_fetch_seq
  import ir_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter int              IR_W     = IR_W_DEF,
  parameter int              OP_W     = OP_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [PC_W-1:0]      rom_addr,
  input  logic [IR_W-1:0]      rom_data,
  output logic                 ins_valid,
  input  logic                 ins_ready,
  output logic [OP_W-1:0]      ins_op,
  output logic [IR_W-OP_W-1:0] ins_operand,
  output logic [PC_W-1:0]      ins_pc,
  input  logic                 acc_neg,
  output logic                 halted
);

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [IR_W-1:0] ir;
  logic [PC_W-1:0] next_pc;

  assign rom_addr    = pc;
  assign ins_op      = ir[IR_W-1:IR_W-OP_W];
  assign ins_operand = ir[IR_W-OP_W-1:0];

  ir_branch_unit #(
    .PC_W (PC_W),
    .OP_W (OP_W)
  ) u_branch (
    .opcode  (ins_op),
    .operand (ins_operand),
    .pc      (pc),
    .acc_neg (acc_neg),
    .next_pc (next_pc)
  );

`ifdef IRF_HALT_EN
  logic halted_q;
  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  // sequencer FSM: capture in FETCH, hold until handshake in ISSUE, PC update at acceptance
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      ir        <= '0;
      ins_pc    <= '0;
      ins_valid <= 1'b0;
`ifdef IRF_HALT_EN
      halted_q  <= 1'b0;
`endif
    end else begin
      case (state)
        FETCH: begin
          ir     <= rom_data;
          ins_pc <= pc;
`ifdef IRF_HALT_EN
          if (rom_data[IR_W-1:IR_W-OP_W] == OP_W'(OP_HLT)) begin
            state    <= HALT;
            halted_q <= 1'b1;
          end else begin
            state     <= ISSUE;
            ins_valid <= 1'b1;
          end
`else
          state     <= ISSUE;
          ins_valid <= 1'b1;
`endif
        end
        ISSUE: begin
          if (ins_ready) begin
            pc        <= next_pc;
            state     <= FETCH;
            ins_valid <= 1'b0;
          end
        end
        HALT: begin
          ins_valid <= 1'b0;
        end
        default: begin
          state     <= FETCH;
          ins_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ir_fetch_seq.sv
// tb_ir_fetch_seq: directed vector table over a hand-written program, reset
// and halt sequences, then randomized programs and handshakes checked against
// an instruction-level model of the PC rules.
module tb_ir_fetch_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        ins_valid;
  logic        ins_ready;
  logic [5:0]  ins_op;
  logic [9:0]  ins_operand;
  logic [7:0]  ins_pc;
  logic        acc_neg;
  logic        halted;

  logic [15:0] rom [256];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  ir_fetch_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .ins_valid   (ins_valid),
    .ins_ready   (ins_ready),
    .ins_op      (ins_op),
    .ins_operand (ins_operand),
    .ins_pc      (ins_pc),
    .acc_neg     (acc_neg),
    .halted      (halted)
  );

  typedef struct {
    logic       neg;
    int         stall;
    logic [7:0] pc;
    logic [5:0] op;
    logic [9:0] opnd;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] w(input logic [5:0] op, input logic [9:0] opnd);
    return {op, opnd};
  endfunction

  // instruction-level PC rule: what address follows pc given its word and the flag
  function automatic logic [7:0] model_next(input logic [7:0] pc, input logic neg);
    logic [15:0] word;
    int op;
    word = rom[pc];
    op   = int'(word[15:10]);
    if (op == 9) return word[7:0];
    if (op == 10 && neg) return word[7:0];
    return pc + 8'd1;
  endfunction

  task automatic do_reset();
    rst_n     = 1'b0;
    ins_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // wait until an instruction is presented; expected gap from FETCH is 1 cycle
  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!ins_valid && n < 10) begin
      tick();
      n++;
    end
    chk(name, n, 1);
  endtask

  vec_t vecs[$];

  initial begin
    rst_n     = 1'b0;
    ins_ready = 1'b0;
    acc_neg   = 1'b0;
    for (int a = 0; a < 256; a++) rom[a] = w(6'd1, 10'd0);

    // program: straight line, backpressure, JMP chain, BAN both ways, wrap
    rom[0]   = w(6'd8, 10'd1);
    rom[1]   = w(6'd8, 10'd2);
    rom[2]   = w(6'd7, 10'd4);
    rom[3]   = w(6'd1, 10'd0);
    rom[4]   = w(6'd9, 10'd12);
    rom[12]  = 16'b0010010000001110;
    rom[13]  = w(6'd6, 10'd99);
    rom[14]  = w(6'd9, 10'd16);
    rom[16]  = w(6'd10, 10'h305);
    rom[5]   = w(6'd9, 10'd16);
    rom[17]  = w(6'd2, 10'd0);
    rom[18]  = w(6'd9, 10'h2FF);
    rom[255] = w(6'd3, 10'd0);

    vecs.push_back('{1'b0, 0, 8'd0,   6'd8,  10'd1});
    vecs.push_back('{1'b0, 3, 8'd1,   6'd8,  10'd2});
    vecs.push_back('{1'b0, 0, 8'd2,   6'd7,  10'd4});
    vecs.push_back('{1'b0, 0, 8'd3,   6'd1,  10'd0});
    vecs.push_back('{1'b0, 0, 8'd4,   6'd9,  10'd12});
    vecs.push_back('{1'b0, 0, 8'd12,  6'd9,  10'd14});
    vecs.push_back('{1'b0, 0, 8'd14,  6'd9,  10'd16});
    vecs.push_back('{1'b1, 0, 8'd16,  6'd10, 10'h305});
    vecs.push_back('{1'b0, 0, 8'd5,   6'd9,  10'd16});
    vecs.push_back('{1'b0, 2, 8'd16,  6'd10, 10'h305});
    vecs.push_back('{1'b0, 0, 8'd17,  6'd2,  10'd0});
    vecs.push_back('{1'b0, 0, 8'd18,  6'd9,  10'h2FF});
    vecs.push_back('{1'b0, 1, 8'd255, 6'd3,  10'd0});
    vecs.push_back('{1'b0, 0, 8'd0,   6'd8,  10'd1});

    // reset state
    tick();
    tick();
    chk("rst_valid", int'(ins_valid), 0);
    chk("rst_op", int'(ins_op), 0);
    chk("rst_operand", int'(ins_operand), 0);
    chk("rst_pc", int'(ins_pc), 0);
    chk("rst_halted", int'(halted), 0);
    chk("rst_rom_addr", int'(rom_addr), 0);
    rst_n = 1'b1;

    // directed vector table
    for (int i = 0; i < vecs.size(); i++) begin
      wait_valid("issue_gap");
      chk("vec_pc", int'(ins_pc), int'(vecs[i].pc));
      chk("vec_op", int'(ins_op), int'(vecs[i].op));
      chk("vec_operand", int'(ins_operand), int'(vecs[i].opnd));
      for (int k = 0; k < vecs[i].stall; k++) begin
        ins_ready = 1'b0;
        acc_neg   = ~vecs[i].neg;
        tick();
        chk("stall_valid", int'(ins_valid), 1);
        chk("stall_op", int'(ins_op), int'(vecs[i].op));
        chk("stall_operand", int'(ins_operand), int'(vecs[i].opnd));
        chk("stall_pc", int'(ins_pc), int'(vecs[i].pc));
      end
      acc_neg   = (vecs[i].op == 6'd10) ? vecs[i].neg : 1'($urandom_range(0, 1));
      ins_ready = 1'b1;
      tick();
      ins_ready = 1'b0;
      acc_neg   = 1'($urandom_range(0, 1));
      chk("post_accept_valid", int'(ins_valid), 0);
      if (i + 1 < vecs.size())
        chk("next_fetch_addr", int'(rom_addr), int'(vecs[i + 1].pc));
    end

    // reset while an instruction is pending
    wait_valid("pre_reset_issue");
    chk("pre_reset_pc", int'(ins_pc), 1);
    rst_n = 1'b0;
    tick();
    chk("mid_reset_valid", int'(ins_valid), 0);
    chk("mid_reset_addr", int'(rom_addr), 0);
    rst_n = 1'b1;
    wait_valid("restart_issue");
    chk("restart_pc", int'(ins_pc), 0);
    chk("restart_op", int'(ins_op), 8);

    // opcode 0 at PC 5: halt with the feature, NOP otherwise
    for (int a = 0; a < 5; a++) rom[a] = w(6'd1, 10'(a));
    rom[5] = 16'h0000;
    rom[6] = w(6'd2, 10'd6);
    rom[7] = w(6'd9, 10'd7);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      wait_valid("halt_prog_issue");
      chk("halt_prog_pc", int'(ins_pc), i);
      ins_ready = 1'b1;
      tick();
      ins_ready = 1'b0;
    end
`ifdef IRF_HALT_EN
    chk("halt_fetch_halted", int'(halted), 0);
    tick();
    for (int c = 0; c < 20; c++) begin
      ins_ready = 1'($urandom_range(0, 1));
      chk("halt_flag", int'(halted), 1);
      chk("halt_valid", int'(ins_valid), 0);
      chk("halt_addr", int'(rom_addr), 5);
      tick();
    end
    ins_ready = 1'b0;
`else
    wait_valid("nop_issue");
    chk("nop_pc", int'(ins_pc), 5);
    chk("nop_op", int'(ins_op), 0);
    ins_ready = 1'b1;
    tick();
    ins_ready = 1'b0;
    wait_valid("after_nop_issue");
    chk("after_nop_pc", int'(ins_pc), 6);
    chk("nop_halted", int'(halted), 0);
`endif

    // randomized programs and handshakes against the instruction-level model
    for (int r = 0; r < 3; r++) begin
      logic [7:0] mpc;
      int accepted;
      int idle_run;
      for (int a = 0; a < 256; a++) begin
        int sel;
        logic [5:0] op;
        sel = $urandom_range(0, 9);
        if (sel < 2) op = 6'd9;
        else if (sel < 4) op = 6'd10;
        else op = 6'($urandom_range(1, 63));
        rom[a] = w(op, 10'($urandom_range(0, 1023)));
      end
      do_reset();
      mpc      = 8'h00;
      accepted = 0;
      idle_run = 0;
      for (int c = 0; c < 700; c++) begin
        chk("rnd_addr", int'(rom_addr), int'(mpc));
        ins_ready = 1'($urandom_range(0, 1));
        acc_neg   = 1'($urandom_range(0, 1));
        if (ins_valid) begin
          idle_run = 0;
          chk("rnd_pc", int'(ins_pc), int'(mpc));
          chk("rnd_word", int'({ins_op, ins_operand}), int'(rom[mpc]));
          if (ins_ready) begin
            mpc = model_next(mpc, acc_neg);
            accepted++;
          end
        end else begin
          idle_run++;
          chk("rnd_idle_run", idle_run, 1);
        end
        tick();
      end
      ins_ready = 1'b0;
      chk("rnd_progress", int'(accepted > 100), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ir_fetch_seq.md
# ir_fetch_seq

Instruction fetch sequencer for the single-cycle CPU. It sits between the PC and the 16-bit instruction ROM: it drives the ROM's 8-bit word address, captures the 16-bit instruction word, and splits it into opcode and operand. It presents each instruction to the execute stage through a valid/ready handshake. It also owns PC update: sequential increment, JMP redirect, and the conditional branch BAN.

## Interface
Parameters:
- PC_W, 8, width of the ROM word address / PC
- IR_W, 16, instruction width
- OP_W, 6, opcode field width, bits [15:10]
- RESET_PC, 8'h00, PC value loaded on reset

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst_n  input  1  reset, synchronous, active-low
- rom_addr  output  PC_W  word address to the instruction ROM; the ROM is combinational
- rom_data  input  IR_W  instruction word returned by the ROM in the same cycle
- ins_valid  output  1  an instruction is presented on ins_op / ins_operand
- ins_ready  input  1  execute stage accepts the instruction
- ins_op  output  OP_W  opcode, ir[15:10]
- ins_operand  output  10  operand field, ir[9:0]
- ins_pc  output  PC_W  address the presented instruction was fetched from
- acc_neg  input  1  accumulator sign flag from the datapath; sampled only at BAN acceptance
- halted  output  1  sequencer stopped; only meaningful when IRF_HALT_EN is defined

## Operation
- Opcodes: CLA=6'd1, COM=6'd2, SHR=6'd3, CSL=6'd4, ADD=6'd6, STA=6'd7, LDA=6'd8, JMP=6'd9, BAN=6'd10, HLT=6'd0. All other codes pass through as ordinary sequential instructions.
- States:
  - RESET: entered while rst_n=0.
  - FETCH: rom_addr=pc; at the clock edge, ir<=rom_data and ins_pc<=pc. Next state is ISSUE, or HALT (see Configuration).
  - ISSUE: ins_valid=1; ins_op, ins_operand and ins_pc are held stable until ins_ready=1. At acceptance the PC updates and the next state is FETCH.
  - HALT: absorbing; it is left only by reset.
- PC update at acceptance:
  - JMP: pc<=operand[7:0].
  - BAN: pc<=operand[7:0] if acc_neg=1, otherwise pc+1.
  - All others: pc<=pc+1.
- operand[9:8] are ignored for branch targets.
- PC arithmetic is modulo 2^PC_W. pc+1 at 8'hFF wraps to 8'h00 with no flag.
- A JMP whose target equals its own address is legal and loops forever.

## Timing
- Reset values, applied at the first edge with rst_n=0:
  - pc=RESET_PC, state=FETCH, ir=0
  - ins_valid=0, ins_op=0, ins_operand=0, ins_pc=0, halted=0
- rom_addr=pc in every state, so it is 8'h00 out of reset.
- Minimum throughput: one instruction per 2 cycles (FETCH, then ISSUE accepted in the same cycle). Each cycle that ins_ready stays low while ins_valid=1 adds one cycle.
- ins_valid is asserted only in ISSUE. Once raised it stays high with stable data until accepted. Deasserting it without a handshake is illegal.
- ins_ready while ins_valid=0 is ignored.
- acc_neg is sampled only in the acceptance cycle of a BAN; it is ignored at all other times.
- Reset mid-operation (rst_n low in ISSUE or HALT): at that edge ins_valid=0 and the instruction is dropped unissued. Fetch restarts at RESET_PC on the first edge after rst_n returns high.
- Undefined ROM words (X in simulation) are not filtered. The bench must not run past initialised ROM content unless IRF_HALT_EN is defined and a HLT word is placed there.

## Configuration
- IRF_HALT_EN defined:
  - An opcode of 0 captured in FETCH sends the sequencer to HALT instead of ISSUE. The HLT word is never presented.
  - In HALT: halted=1 from the next cycle on, ins_valid=0, and pc is frozen at the HLT address.
- IRF_HALT_EN not defined:
  - Opcode 0 is an ordinary NOP: issued, then pc+1.
  - HALT is unreachable and halted is tied to 0.

## Structure
- Shared package ir_pkg holds:
  - the opcode localparams, also used by the execute-stage decoder
  - the OP_W and PC_W defaults
  - the state enum {FETCH, ISSUE, HALT}
- One sub-module, ir_branch_unit: combinational. Inputs are opcode, operand, pc and acc_neg; output is next_pc. It isolates the JMP/BAN/increment selection from the state machine.

## Test plan
- Straight line: ROM 0..3 = LDA 1, LDA 2, STA 4, CLA with ins_ready tied high → ins_pc sequence 0,1,2,3. ins_valid is high every second cycle. ins_op sequence 8,8,7,1.
- Backpressure: ins_ready low for 3 cycles on the instruction at PC 1 (LDA 2) → ins_valid held 4 cycles, ins_op/ins_operand stable. Next fetch address is 2.
- JMP: word 16'b0010010000001110 at PC 12 → next ins_pc=14. PC 13 is never presented.
- BAN: BAN target 8'h05 at PC 16 → with acc_neg=1 next ins_pc=5; with acc_neg=0 next ins_pc=17.
- Wrap and reset: force pc=8'hFF with a non-branch word there → next ins_pc=0. Pull rst_n low in ISSUE → ins_valid=0 at that edge and fetch restarts at RESET_PC.
- Halt, with IRF_HALT_EN defined: 16'h0000 at PC 5 → after PC 4 is accepted, halted=1, ins_valid stays 0, rom_addr stays 5 for 20 cycles. Without the macro, PC 5 is issued as op 0 and PC 6 follows.
